hpdmc_initseq: RTL and testbench

HPDMC_INITSEQ -- requirements
Module: hpdmc_initseq

---
 rtl/hpdmc_initseq.sv | 224 ++++++++++++++++++++++
 tb/tb_hpdmc_initseq.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdmc_initseq.sv
// SDRAM power-up initialisation sequencer: drives PRE/EMRS/MRS/REFRESH with
// programmable gaps, then hands the command bus to the scheduler.
module hpdmc_initseq #(
    parameter logic [15:0] POWERUP_WAIT = 16'd20000,
    parameter int unsigned NUM_REFRESH  = 2
) (
    input  logic        sys_clk,
    input  logic        sdram_rst,
    input  logic        start,
    input  logic [2:0]  tim_rp,
    input  logic [3:0]  tim_rfc,
    input  logic [1:0]  tim_mrd,
    input  logic [12:0] mode_reg,
    input  logic [12:0] ext_mode_reg,
    input  logic        sched_cs_n,
    input  logic        sched_ras_n,
    input  logic        sched_cas_n,
    input  logic        sched_we_n,
    input  logic [12:0] sched_adr,
    input  logic [1:0]  sched_ba,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [12:0] sdram_adr,
    output logic [1:0]  sdram_ba,
    output logic        init_done,
    output logic        busy
);

    localparam int unsigned AW  = 13;
    localparam int unsigned BW  = 2;
    localparam int unsigned WW  = 4;
    localparam int unsigned PW  = 16;
    localparam int unsigned RW  = 4;
    localparam int unsigned RCW = RW + 1;

    localparam logic [3:0]    CMD_NOP = 4'b0111;
    localparam logic [3:0]    CMD_PRE = 4'b0010;
    localparam logic [3:0]    CMD_REF = 4'b0001;
    localparam logic [3:0]    CMD_MRS = 4'b0000;
    localparam logic [AW-1:0] ADR_A10 = 13'h0400;
    localparam logic [AW-1:0] ADR_A8  = 13'h0100;

    typedef enum logic [3:0] {
        S_IDLE,
        S_PWR_WAIT,
        S_PRE1,
        S_EMRS,
        S_MRS_DLLRST,
        S_PRE2,
        S_REFRESH,
        S_MRS_FINAL,
        S_DONE
    } state_t;

    state_t        state, state_nx, dest;
    logic          first, first_nx;
    logic [WW-1:0] wait_cnt, wait_nx, t_load;
    logic [PW-1:0] pwr_cnt, pwr_nx;
    logic [RW-1:0] ref_cnt, ref_nx;
    logic [RCW-1:0] ref_issued;
    logic          is_cmd;
    logic          cke_q, cke_nx;
    logic [3:0]    cmd_q, cmd_nx;
    logic [AW-1:0] adr_q, adr_nx;
    logic [BW-1:0] ba_q, ba_nx;
    logic          busy_q, busy_nx;
    logic          done_q, done_nx;

    // Next-state and next-output logic; first marks the command-issue cycle of a state
    always_comb begin
        state_nx   = state;
        first_nx   = 1'b0;
        wait_nx    = wait_cnt;
        pwr_nx     = pwr_cnt;
        ref_nx     = ref_cnt;
        cke_nx     = 1'b1;
        cmd_nx     = CMD_NOP;
        adr_nx     = '0;
        ba_nx      = '0;
        is_cmd     = 1'b0;
        t_load     = '0;
        dest       = state;
        ref_issued = RCW'(ref_cnt) + (first ? RCW'(1) : RCW'(0));
        busy_nx    = (state != S_IDLE) && (state != S_DONE);
        done_nx    = (state == S_DONE);

        case (state)
            S_IDLE: begin
                cke_nx  = 1'b0;
                wait_nx = '0;
                ref_nx  = '0;
                pwr_nx  = '0;
                if (start) begin
                    state_nx = S_PWR_WAIT;
                    pwr_nx   = POWERUP_WAIT;
                end
            end
            S_PWR_WAIT: begin
                if (pwr_cnt <= PW'(1)) begin
                    state_nx = S_PRE1;
                    first_nx = 1'b1;
                end else begin
                    pwr_nx = pwr_cnt - PW'(1);
                end
            end
            S_PRE1: begin
                is_cmd = 1'b1;
                t_load = WW'(tim_rp);
                dest   = S_EMRS;
                if (first) begin
                    cmd_nx = CMD_PRE;
                    adr_nx = ADR_A10;
                end
            end
            S_EMRS: begin
                is_cmd = 1'b1;
                t_load = WW'(tim_mrd);
                dest   = S_MRS_DLLRST;
                if (first) begin
                    cmd_nx = CMD_MRS;
                    adr_nx = ext_mode_reg;
                    ba_nx  = 2'b01;
                end
            end
            S_MRS_DLLRST: begin
                is_cmd = 1'b1;
                t_load = WW'(tim_mrd);
                dest   = S_PRE2;
                if (first) begin
                    cmd_nx = CMD_MRS;
                    adr_nx = mode_reg | ADR_A8;
                end
            end
            S_PRE2: begin
                is_cmd = 1'b1;
                t_load = WW'(tim_rp);
                dest   = S_REFRESH;
                if (first) begin
                    cmd_nx = CMD_PRE;
                    adr_nx = ADR_A10;
                end
            end
            S_REFRESH: begin
                is_cmd = 1'b1;
                t_load = tim_rfc;
                dest   = (ref_issued >= RCW'(NUM_REFRESH)) ? S_MRS_FINAL : S_REFRESH;
                if (first) begin
                    cmd_nx = CMD_REF;
                    ref_nx = ref_cnt + RW'(1);
                end
            end
            S_MRS_FINAL: begin
                is_cmd = 1'b1;
                t_load = WW'(tim_mrd);
                dest   = S_DONE;
                if (first) begin
                    cmd_nx = CMD_MRS;
                    adr_nx = mode_reg & ~ADR_A8;
                end
            end
            S_DONE: begin
                cke_nx = 1'b1;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase

        // Shared command/wait sub-sequencer: timing is sampled only on the issue cycle
        if (is_cmd) begin
            if (first && (t_load != '0)) begin
                wait_nx = t_load;
            end else if (first || (wait_cnt <= WW'(1))) begin
                state_nx = dest;
                first_nx = 1'b1;
            end else begin
                wait_nx = wait_cnt - WW'(1);
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sdram_rst) begin
            state    <= S_IDLE;
            first    <= 1'b0;
            wait_cnt <= '0;
            pwr_cnt  <= '0;
            ref_cnt  <= '0;
            cke_q    <= 1'b0;
            cmd_q    <= 4'b1111;
            adr_q    <= '0;
            ba_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_nx;
            first    <= first_nx;
            wait_cnt <= wait_nx;
            pwr_cnt  <= pwr_nx;
            ref_cnt  <= ref_nx;
            cke_q    <= cke_nx;
            cmd_q    <= cmd_nx;
            adr_q    <= adr_nx;
            ba_q     <= ba_nx;
            busy_q   <= busy_nx;
            done_q   <= done_nx;
        end
    end

    // Once init is complete the scheduler drives the pins directly
    assign sdram_cke   = cke_q;
    assign sdram_cs_n  = done_q ? sched_cs_n  : cmd_q[3];
    assign sdram_ras_n = done_q ? sched_ras_n : cmd_q[2];
    assign sdram_cas_n = done_q ? sched_cas_n : cmd_q[1];
    assign sdram_we_n  = done_q ? sched_we_n  : cmd_q[0];
    assign sdram_adr   = done_q ? sched_adr   : adr_q;
    assign sdram_ba    = done_q ? sched_ba    : ba_q;
    assign init_done   = done_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_hpdmc_initseq.sv
// Scoreboard bench for hpdmc_initseq: expected commands with their preceding
// NOP gaps are queued by the stimulus and checked by a bus monitor.
`timescale 1ns/1ps
module tb_hpdmc_initseq;

    localparam logic [3:0] C_NOP  = 4'b0111;
    localparam logic [3:0] C_PRE  = 4'b0010;
    localparam logic [3:0] C_REF  = 4'b0001;
    localparam logic [3:0] C_MRS  = 4'b0000;
    localparam logic [3:0] C_DONE = 4'b1111;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [12:0] adr;
        logic [1:0]  ba;
        logic [7:0]  gap;
    } exp_t;

    logic sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        sdram_rst, start, start15, rst15;
    logic [2:0]  tim_rp;
    logic [3:0]  tim_rfc;
    logic [1:0]  tim_mrd;
    logic [12:0] mode_reg, ext_mode_reg;
    logic        sched_cs_n, sched_ras_n, sched_cas_n, sched_we_n;
    logic [12:0] sched_adr;
    logic [1:0]  sched_ba;

    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [12:0] sdram_adr;
    logic [1:0]  sdram_ba;
    logic        init_done, busy;

    logic        cke_b, cs_n_b, ras_n_b, cas_n_b, we_n_b;
    logic [12:0] adr_b;
    logic [1:0]  ba_b;
    logic        init_done_b, busy_b;

    hpdmc_initseq #(.POWERUP_WAIT(16'd4), .NUM_REFRESH(2)) dut (
        .sys_clk(sys_clk), .sdram_rst(sdram_rst), .start(start),
        .tim_rp(tim_rp), .tim_rfc(tim_rfc), .tim_mrd(tim_mrd),
        .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
        .sched_cs_n(sched_cs_n), .sched_ras_n(sched_ras_n),
        .sched_cas_n(sched_cas_n), .sched_we_n(sched_we_n),
        .sched_adr(sched_adr), .sched_ba(sched_ba),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
        .sdram_adr(sdram_adr), .sdram_ba(sdram_ba),
        .init_done(init_done), .busy(busy)
    );

    hpdmc_initseq #(.POWERUP_WAIT(16'd4), .NUM_REFRESH(15)) dut15 (
        .sys_clk(sys_clk), .sdram_rst(rst15), .start(start15),
        .tim_rp(tim_rp), .tim_rfc(tim_rfc), .tim_mrd(tim_mrd),
        .mode_reg(mode_reg), .ext_mode_reg(ext_mode_reg),
        .sched_cs_n(sched_cs_n), .sched_ras_n(sched_ras_n),
        .sched_cas_n(sched_cas_n), .sched_we_n(sched_we_n),
        .sched_adr(sched_adr), .sched_ba(sched_ba),
        .sdram_cke(cke_b), .sdram_cs_n(cs_n_b), .sdram_ras_n(ras_n_b),
        .sdram_cas_n(cas_n_b), .sdram_we_n(we_n_b),
        .sdram_adr(adr_b), .sdram_ba(ba_b),
        .init_done(init_done_b), .busy(busy_b)
    );

    logic [3:0] bus, bus_b;
    assign bus   = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};
    assign bus_b = {cs_n_b, ras_n_b, cas_n_b, we_n_b};

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[$];
    int   gap = 0;
    int   cmd_seen = 0;
    bit   done_seen = 1'b0;
    int   ref15 = 0;
    int   ref15_at_mrs = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b, input int g);
        exp_t e;
        e.cmd = c; e.adr = a; e.ba = b; e.gap = 8'(g);
        exp_q.push_back(e);
    endtask

    task automatic pop_cmp(input logic [3:0] c, input logic [12:0] a, input logic [1:0] b, input int g);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_cmd actual cmd=%b adr=%h ba=%0d gap=%0d required=none", c, a, b, g);
        end else begin
            e = exp_q.pop_front();
            if ({c, a, b, 8'(g)} !== {e.cmd, e.adr, e.ba, e.gap}) begin
                failures++;
                $display("FAIL bus_cmd actual cmd=%b adr=%h ba=%0d gap=%0d required cmd=%b adr=%h ba=%0d gap=%0d",
                         c, a, b, g, e.cmd, e.adr, e.ba, e.gap);
            end
        end
    endtask

    // Monitor: every non-NOP command (and the init_done rise) pops one expectation
    always @(negedge sys_clk) begin
        if (sdram_rst) begin
            gap = 0;
            done_seen = 1'b0;
        end else if (init_done) begin
            if (!done_seen) begin
                done_seen = 1'b1;
                pop_cmp(C_DONE, 13'h0, 2'h0, gap);
            end
        end else if (!sdram_cke) begin
            gap = 0;
        end else if (bus == C_NOP) begin
            gap++;
        end else begin
            pop_cmp(bus, sdram_adr, sdram_ba, gap);
            cmd_seen++;
            gap = 0;
        end
    end

    always @(negedge sys_clk) begin
        if (init_done_b !== 1'b1 && cke_b === 1'b1) begin
            if (bus_b == C_REF) ref15++;
            if (bus_b == C_MRS && ba_b == 2'd0 && !adr_b[8] && ref15_at_mrs < 0)
                ref15_at_mrs = ref15;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic pulse_start();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic wait_cmds(input int n);
        int k = 0;
        while (cmd_seen < n && k < 300) begin
            tick();
            k++;
        end
        chk("cmd_reach", 32'(cmd_seen >= n), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (init_done !== 1'b1 && k < 400) begin
            tick();
            k++;
        end
        chk(name, 32'(init_done), 32'd1);
    endtask

    task automatic push_nominal(input int rp2_gap);
        push(C_PRE, 13'h400, 2'd0, 4);
        push(C_MRS, 13'h000, 2'd1, 2);
        push(C_MRS, 13'h132, 2'd0, 1);
        push(C_PRE, 13'h400, 2'd0, 1);
        push(C_REF, 13'h000, 2'd0, rp2_gap);
        push(C_REF, 13'h000, 2'd0, 5);
        push(C_MRS, 13'h032, 2'd0, 5);
        push(C_DONE, 13'h000, 2'd0, 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        sdram_rst = 1'b1; rst15 = 1'b1; start = 1'b0; start15 = 1'b0;
        tim_rp = 3'd2; tim_mrd = 2'd1; tim_rfc = 4'd5;
        mode_reg = 13'h032; ext_mode_reg = 13'h000;
        sched_cs_n = 1'b0; sched_ras_n = 1'b0; sched_cas_n = 1'b0; sched_we_n = 1'b0;
        sched_adr = 13'h1FFF; sched_ba = 2'd3;
        repeat (3) tick();

        // Reset state must ignore sched_* and present an idle bus
        chk("rst_bus", 32'({bus, sdram_adr, sdram_ba}), 32'({4'b1111, 13'h0, 2'h0}));
        chk("rst_cke", 32'(sdram_cke), 32'd0);
        chk("rst_done", 32'(init_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);

        // Nominal sequence, sched_* driving a REFRESH throughout
        sdram_rst = 1'b0; rst15 = 1'b0; start15 = 1'b1;
        sched_cs_n = 1'b0; sched_ras_n = 1'b0; sched_cas_n = 1'b0; sched_we_n = 1'b1;
        sched_adr = 13'h1AB; sched_ba = 2'd3;
        base = cmd_seen;
        push_nominal(7);
        pulse_start();
        tick();
        chk("pwr_bus", 32'(bus), 32'(C_NOP));
        chk("pwr_cke", 32'(sdram_cke), 32'd1);
        chk("pwr_busy", 32'(busy), 32'd1);
        wait_cmds(base + 1);
        tim_rp = 3'd7;
        wait_cmds(base + 2);
        start = 1'b1;
        wait_cmds(base + 4);
        start = 1'b0;
        wait_done("nominal_done");
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_cke", 32'(sdram_cke), 32'd1);
        chk("pass_thru1", 32'({bus, sdram_adr, sdram_ba}), 32'({4'b0001, 13'h1AB, 2'd3}));
        tick();
        sched_cs_n = 1'b1; sched_ras_n = 1'b0; sched_cas_n = 1'b1; sched_we_n = 1'b0;
        sched_adr = 13'h0F0; sched_ba = 2'd2; start = 1'b1;
        #1;
        chk("pass_thru2", 32'({bus, sdram_adr, sdram_ba}), 32'({4'b1010, 13'h0F0, 2'd2}));
        repeat (5) tick();
        start = 1'b0;
        repeat (3) tick();
        chk("done_hold", 32'(init_done), 32'd1);
        chk("nominal_q_empty", 32'(exp_q.size()), 32'd0);

        // Zero waits: commands back to back
        sdram_rst = 1'b1;
        tick();
        sdram_rst = 1'b0; tim_rp = 3'd0; tim_mrd = 2'd0; tim_rfc = 4'd0;
        sched_cs_n = 1'b0; sched_ras_n = 1'b0; sched_cas_n = 1'b0; sched_we_n = 1'b1;
        push(C_PRE, 13'h400, 2'd0, 4);
        push(C_MRS, 13'h000, 2'd1, 0);
        push(C_MRS, 13'h132, 2'd0, 0);
        push(C_PRE, 13'h400, 2'd0, 0);
        push(C_REF, 13'h000, 2'd0, 0);
        push(C_REF, 13'h000, 2'd0, 0);
        push(C_MRS, 13'h032, 2'd0, 0);
        push(C_DONE, 13'h000, 2'd0, 0);
        pulse_start();
        wait_done("zero_done");
        tick();
        chk("zero_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset during the second REFRESH wait aborts, then a restart runs in full
        sdram_rst = 1'b1;
        tick();
        sdram_rst = 1'b0; tim_rp = 3'd2; tim_mrd = 2'd1; tim_rfc = 4'd5;
        base = cmd_seen;
        push(C_PRE, 13'h400, 2'd0, 4);
        push(C_MRS, 13'h000, 2'd1, 2);
        push(C_MRS, 13'h132, 2'd0, 1);
        push(C_PRE, 13'h400, 2'd0, 1);
        push(C_REF, 13'h000, 2'd0, 2);
        push(C_REF, 13'h000, 2'd0, 5);
        pulse_start();
        wait_cmds(base + 6);
        sdram_rst = 1'b1;
        tick();
        chk("abort_cke", 32'(sdram_cke), 32'd0);
        chk("abort_bus", 32'(bus), 32'b1111);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(init_done), 32'd0);
        sdram_rst = 1'b0;
        repeat (20) tick();
        chk("abort_no_cmds", 32'(cmd_seen - base), 32'd6);
        chk("abort_q_empty", 32'(exp_q.size()), 32'd0);
        push_nominal(2);
        pulse_start();
        wait_done("restart_done");
        tick();
        chk("restart_q_empty", 32'(exp_q.size()), 32'd0);

        // Fifteen refreshes on the second instance
        chk("ref15_count", 32'(ref15_at_mrs), 32'd15);
        chk("ref15_done", 32'(init_done_b), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
